emulador_de_teclado: RTL
========================

# emulador_de_teclado

Synthesizable model of a 4x4 membrane keypad: the passive end of the row-scan/column-sense matrix interface driven by the keypad decoder. A single-cycle command handshake accepts a key code. The block then closes the selected contact with deterministic press bounce, a stable hold, release bounce and a quiet gap. While the contact is closed, it pulls the matching column line low whenever the decoder drives that key's row low. It is used on-board and in simulation to exercise the decoder without physical buttons.

## Interface
Parameters:
- BOUNCE_PERIOD, 3: cycles between contact toggles during bounce; must be ≥1.
- BOUNCE_TOGGLES, 4: number of contact inversions per bounce phase; even and ≥0; 0 disables bounce.
- HOLD_CYCLES, 200: cycles the contact stays stably closed; must be ≥1.
- GAP_CYCLES, 50: cycles the contact stays stably open after release before the next command; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tecla_cmd  in  4  key code to press; row r = tecla_cmd[3:2], column c = tecla_cmd[1:0].
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle and able to accept a command.
- lin_matriz  in  4  row drive from the decoder, active-low; row r is active when lin_matriz[3-r] = 0.
- col_matriz  out  4  column sense to the decoder, active-low, 4'b1111 when no contact.
- busy  out  1  equals !cmd_ready.
- key_done  out  1  one-cycle pulse when a press/release sequence completes.

## Operation
- The states are IDLE, BOUNCE_PRESS, HOLD, BOUNCE_RELEASE and GAP. An internal `contact` bit means the key switch is closed.
- Columns are combinational and have no clock delay:
  - When contact = 1 and lin_matriz[3-r] = 0, col_matriz = 4'b1111 with bit (3-c) cleared.
  - Otherwise col_matriz = 4'b1111.
  - With several rows low, the key's row is still the only one that matters.
- IDLE:
  - cmd_ready = 1 and contact = 0.
  - When cmd_valid && cmd_ready at an edge, the block latches tecla_cmd into its key register.
  - It then enters BOUNCE_PRESS, or HOLD if BOUNCE_TOGGLES = 0.
- BOUNCE_PRESS:
  - Contact starts closed.
  - A period counter counts 0..BOUNCE_PERIOD-1; at each wrap the toggle counter increments and the contact inverts.
  - Contact = 1 when the toggle count is even.
  - After BOUNCE_TOGGLES toggles (contact closed again), the block enters HOLD.
- HOLD: contact = 1 for HOLD_CYCLES cycles, then the block enters BOUNCE_RELEASE, or GAP if BOUNCE_TOGGLES = 0.
- BOUNCE_RELEASE: the same toggle scheme as BOUNCE_PRESS, but contact starts open (open when the toggle count is even) and ends open. The block then enters GAP.
- GAP: contact = 0 for GAP_CYCLES cycles, then the block returns to IDLE.
- key_done is registered. It is high exactly in the first IDLE cycle after GAP, coincident with cmd_ready returning to 1.
- Commands:
  - cmd_valid while busy is ignored: no queueing and no error.
  - tecla_cmd changes after acceptance do not affect the key in progress.
- Counter widths are $clog2(max(param, 2)) bits. Counters clear on every state entry.

## Timing
- Reset: state IDLE, contact 0, key register 4'h0, counters 0, key_done 0. As a result col_matriz = 4'b1111, cmd_ready = 1 and busy = 0.
- Reset takes effect immediately and asynchronously. A reset asserted mid-sequence opens the contact in the same instant, and no key_done is produced.
- Acceptance edge is k. Contact is closed during cycle k+1, and cmd_ready = 0 from k+1.
- Phase durations:
  - BOUNCE_PRESS: BOUNCE_TOGGLES*BOUNCE_PERIOD cycles.
  - HOLD: HOLD_CYCLES cycles.
  - BOUNCE_RELEASE: BOUNCE_TOGGLES*BOUNCE_PERIOD cycles.
  - GAP: GAP_CYCLES cycles.
- key_done and cmd_ready = 1 occur at cycle k+1+N, where N = 2*BOUNCE_TOGGLES*BOUNCE_PERIOD + HOLD_CYCLES + GAP_CYCLES. With defaults, N = 274.
- Back-to-back commands: a command held valid during the key_done cycle is accepted at that edge, so the block has one IDLE cycle between sequences.
- During bounce, each contact level lasts exactly BOUNCE_PERIOD cycles.

## Test plan
- Reset check: hold rst with lin_matriz = 4'b0000 -> col_matriz = 4'b1111, cmd_ready = 1, key_done = 0.
- Key 5 (r1, c1):
  - Stimulus: accept tecla_cmd = 4'h5 at edge k; lin_matriz = 4'b1011 constant.
  - col_matriz = 4'b1011 in cycles k+1..k+3.
  - col_matriz = 4'b1111 in cycles k+4..k+6.
  - Pattern repeats for 4 toggles, then col_matriz = 4'b1011 through the end of HOLD.
  - key_done pulses once at k+275.
- Row selectivity: accept key 4'hE (r3, c2) and cycle lin_matriz through 0111/1011/1101/1110 during HOLD -> col_matriz = 4'b1101 only while lin_matriz = 4'b1110; 4'b1111 otherwise.
- Busy ignore: pulse cmd_valid with tecla_cmd = 4'h3 during HOLD of a 4'h0 press -> cmd_ready stays 0, the key stays 4'h0, and exactly one key_done is produced.
- Reset mid-operation: assert rst during HOLD of key 4'hA -> col_matriz = 4'b1111 immediately and cmd_ready = 1. No key_done follows, and a new command is accepted after rst deasserts.
- BOUNCE_TOGGLES = 0 with HOLD_CYCLES = 5 and GAP_CYCLES = 2 -> a clean 5-cycle closure, no intermediate toggles, and key_done at k+8.

Source files
------------

// File: rtl/emulador_de_teclado.sv
// 4x4 membrane keypad emulator: accepts a key code and replays a press with
// deterministic contact bounce, a stable hold, release bounce and a quiet gap,
// answering the decoder's active-low row scan on the active-low column lines.
module emulador_de_teclado #(
  parameter int BOUNCE_PERIOD  = 3,
  parameter int BOUNCE_TOGGLES = 4,
  parameter int HOLD_CYCLES    = 200,
  parameter int GAP_CYCLES     = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] tecla_cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] lin_matriz,
  output logic [3:0] col_matriz,
  output logic       busy,
  output logic       key_done
);

  localparam int PMAX = (BOUNCE_PERIOD  > 2) ? BOUNCE_PERIOD  : 2;
  localparam int TMAX = (BOUNCE_TOGGLES > 2) ? BOUNCE_TOGGLES : 2;
  localparam int HMAX = (HOLD_CYCLES    > 2) ? HOLD_CYCLES    : 2;
  localparam int GMAX = (GAP_CYCLES     > 2) ? GAP_CYCLES     : 2;
  localparam int PW   = $clog2(PMAX);
  localparam int TW   = $clog2(TMAX);
  localparam int HW   = $clog2(HMAX);
  localparam int GW   = $clog2(GMAX);
  // HOLD and GAP never overlap, so they share one phase counter
  localparam int CW   = (HW > GW) ? HW : GW;

  localparam logic [PW-1:0] PER_LAST  = PW'(BOUNCE_PERIOD - 1);
  // With bounce disabled TMAX-1 is never reached; it only keeps the cast in range
  localparam logic [TW-1:0] TOG_LAST  = TW'(TMAX - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam bit            NO_BOUNCE = (BOUNCE_TOGGLES == 0);

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_PRESS,
    HOLD,
    BOUNCE_RELEASE,
    GAP
  } state_t;

  state_t        state_reg, state_next;
  logic [3:0]    key_reg, key_next;
  logic [PW-1:0] per_cnt_reg, per_cnt_next;
  logic [TW-1:0] tog_cnt_reg, tog_cnt_next;
  logic [CW-1:0] ph_cnt_reg, ph_cnt_next;
  logic          key_done_reg, key_done_next;
  logic          contact;
  logic [1:0]    lin_idx;
  logic          row_active;

  // State, key and counter registers; reset drops the contact at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      key_reg      <= 4'h0;
      per_cnt_reg  <= '0;
      tog_cnt_reg  <= '0;
      ph_cnt_reg   <= '0;
      key_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      key_reg      <= key_next;
      per_cnt_reg  <= per_cnt_next;
      tog_cnt_reg  <= tog_cnt_next;
      ph_cnt_reg   <= ph_cnt_next;
      key_done_reg <= key_done_next;
    end
  end

  // Next-state logic; every transition clears the counters for the new phase
  always_comb begin
    state_next    = state_reg;
    key_next      = key_reg;
    per_cnt_next  = per_cnt_reg;
    tog_cnt_next  = tog_cnt_reg;
    ph_cnt_next   = ph_cnt_reg;
    key_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          key_next     = tecla_cmd;
          state_next   = NO_BOUNCE ? HOLD : BOUNCE_PRESS;
          per_cnt_next = '0;
          tog_cnt_next = '0;
          ph_cnt_next  = '0;
        end
      end
      BOUNCE_PRESS, BOUNCE_RELEASE: begin
        if (per_cnt_reg == PER_LAST) begin
          per_cnt_next = '0;
          if (tog_cnt_reg == TOG_LAST) begin
            state_next   = (state_reg == BOUNCE_PRESS) ? HOLD : GAP;
            tog_cnt_next = '0;
            ph_cnt_next  = '0;
          end else begin
            tog_cnt_next = tog_cnt_reg + 1'b1;
          end
        end else begin
          per_cnt_next = per_cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (ph_cnt_reg == HOLD_LAST) begin
          state_next   = NO_BOUNCE ? GAP : BOUNCE_RELEASE;
          ph_cnt_next  = '0;
          per_cnt_next = '0;
          tog_cnt_next = '0;
        end else begin
          ph_cnt_next = ph_cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (ph_cnt_reg == GAP_LAST) begin
          state_next    = IDLE;
          ph_cnt_next   = '0;
          key_done_next = 1'b1;
        end else begin
          ph_cnt_next = ph_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Contact level per phase: press bounce closed on even toggles, release bounce open
  always_comb begin
    contact = 1'b0;
    case (state_reg)
      BOUNCE_PRESS:   contact = ~tog_cnt_reg[0];
      HOLD:           contact = 1'b1;
      BOUNCE_RELEASE: contact = tog_cnt_reg[0];
      default:        contact = 1'b0;
    endcase
  end

  // Only the latched key's row is looked at, however many rows are driven low
  assign lin_idx    = 2'd3 - key_reg[3:2];
  assign row_active = ~lin_matriz[lin_idx];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign col_matriz[3-gi] = ~(contact && row_active && (key_reg[1:0] == 2'(gi)));
    end
  endgenerate

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = ~cmd_ready;
  assign key_done  = key_done_reg;

endmodule
